// File: rtl/dispatch_ctrl.sv
// Dispatch-width controller: grants 0..2 in-order dispatches per cycle.
// Optional perf counters: define DISPATCH_PERF_CNT_EN.
module dispatch_ctrl #(
  parameter int N_ENTRY_ROB   = 32,
  parameter int N_ENTRY_RS    = 16,
  parameter int N_FREE_PR     = 64,
  parameter int RECOVER_STALL = 2,
  localparam int CW  = $clog2(N_ENTRY_ROB+1),
  localparam int RSW = $clog2(N_ENTRY_RS+1),
  localparam int FLW = $clog2(N_FREE_PR+1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req_0,
  input  logic           req_1,
  input  logic           halt_0,
  input  logic           halt_1,
  input  logic [RSW-1:0] rs_free_cnt,
  input  logic [FLW-1:0] fl_free_cnt,
  input  logic           rt_valid_0,
  input  logic           rt_valid_1,
  input  logic           recovery_br,
  input  logic [CW-1:0]  recovery_cnt,
  output logic           grant_0,
  output logic           grant_1,
  output logic [CW-1:0]  rob_count,
  output logic           rob_full,
  output logic [1:0]     state,
  output logic           stall
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]    perf_stall_rob,
  output logic [31:0]    perf_stall_rs,
  output logic [31:0]    perf_stall_fl
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    RECOVER = 2'b01,
    HALTED  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    rcnt_q, rcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rob_space, space;
  logic [31:0]   add_sum, ret_sum, upd;
  logic          run, halt_hit;

  always_comb begin
    rob_space = 32'(N_ENTRY_ROB) - 32'(cnt_q);
    space = rob_space;
    if (32'(rs_free_cnt) < space) space = 32'(rs_free_cnt);
    if (32'(fl_free_cnt) < space) space = 32'(fl_free_cnt);
  end

  assign run = (state_q == RUN) && !recovery_br && !reset;
  assign grant_0 = run && req_0 && (space >= 32'd1);
  assign grant_1 = grant_0 && req_1 && !halt_0
                   && (space >= 32'd2);
  assign halt_hit = (grant_0 && halt_0) || (grant_1 && halt_1);
  assign stall = req_0 && !grant_0 && !reset;

  // Over-retire saturates at zero rather than wrapping
  always_comb begin
    add_sum = 32'(cnt_q) + 32'(grant_0) + 32'(grant_1);
    ret_sum = 32'(rt_valid_0) + 32'(rt_valid_1);
    upd = (add_sum < ret_sum) ? 32'd0 : add_sum - ret_sum;
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cnt_d   = CW'(upd);
    if (recovery_br) begin
      state_d = RECOVER;
      rcnt_d  = 3'(RECOVER_STALL - 1);
      cnt_d   = recovery_cnt;
    end else begin
      unique case (state_q)
        RUN: if (halt_hit) state_d = HALTED;
        RECOVER: begin
          if (rcnt_q == 3'd0) state_d = RUN;
          else rcnt_d = rcnt_q - 3'd1;
        end
        HALTED: ;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && !recovery_br) begin
      assert (add_sum >= ret_sum)
        else $error("dispatch_ctrl: retire underflow");
    end
    if (!reset) begin
      assert (32'(cnt_q) <= 32'(N_ENTRY_ROB))
        else $error("dispatch_ctrl: rob_count overflow");
    end
  end
`endif

  assign rob_count = cnt_q;
  assign rob_full  = (32'(cnt_q) == 32'(N_ENTRY_ROB));
  assign state     = state_q;

`ifdef DISPATCH_PERF_CNT_EN
  logic blk;
  assign blk = (state_q == RUN) && req_0 && !grant_0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_rob <= '0;
      perf_stall_rs  <= '0;
      perf_stall_fl  <= '0;
    end else begin
      if (blk && rob_space == 32'd0 && perf_stall_rob != '1)
        perf_stall_rob <= perf_stall_rob + 32'd1;
      if (blk && rs_free_cnt == '0 && perf_stall_rs != '1)
        perf_stall_rs <= perf_stall_rs + 32'd1;
      if (blk && fl_free_cnt == '0 && perf_stall_fl != '1)
        perf_stall_fl <= perf_stall_fl + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: cycle model compare plus directed literals.
// Perf counter ports are checked when DISPATCH_PERF_CNT_EN is defined.
module tb_dispatch_ctrl;
  localparam int NROB = 32;
  localparam int NRS  = 16;
  localparam int NFL  = 64;
  localparam int RST  = 2;

  logic       clock = 0;
  logic       reset;
  logic       req_0, req_1, halt_0, halt_1;
  logic [4:0] rs_free_cnt;
  logic [6:0] fl_free_cnt;
  logic       rt_valid_0, rt_valid_1;
  logic       recovery_br;
  logic [5:0] recovery_cnt;
  logic       grant_0, grant_1;
  logic [5:0] rob_count;
  logic       rob_full;
  logic [1:0] state;
  logic       stall;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_stall_rob, perf_stall_rs, perf_stall_fl;
`endif

  dispatch_ctrl #(
    .N_ENTRY_ROB(NROB), .N_ENTRY_RS(NRS),
    .N_FREE_PR(NFL), .RECOVER_STALL(RST)
  ) dut (
    .clock(clock), .reset(reset),
    .req_0(req_0), .req_1(req_1),
    .halt_0(halt_0), .halt_1(halt_1),
    .rs_free_cnt(rs_free_cnt), .fl_free_cnt(fl_free_cnt),
    .rt_valid_0(rt_valid_0), .rt_valid_1(rt_valid_1),
    .recovery_br(recovery_br), .recovery_cnt(recovery_cnt),
    .grant_0(grant_0), .grant_1(grant_1),
    .rob_count(rob_count), .rob_full(rob_full),
    .state(state), .stall(stall)
`ifdef DISPATCH_PERF_CNT_EN
    , .perf_stall_rob(perf_stall_rob),
    .perf_stall_rs(perf_stall_rs),
    .perf_stall_fl(perf_stall_fl)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model: occupancy, blocked cycles left after a recovery, halted flag
  int m_cnt, m_block, m_halted;
  int m_prob, m_prs, m_pfl;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int min3(int a, int b, int c);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic bit m_run();
    return (m_halted == 0) && (m_block == 0);
  endfunction

  function automatic void exp_g(output bit e0, output bit e1);
    int sp;
    bit ok;
    sp = min3(NROB - m_cnt, int'(rs_free_cnt), int'(fl_free_cnt));
    ok = m_run() && !recovery_br && !reset;
    e0 = ok && req_0 && sp >= 1;
    e1 = e0 && req_1 && sp >= 2 && !halt_0;
  endfunction

  bit u0, u1;
  int tot;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_block = 0; m_halted = 0;
      m_prob = 0; m_prs = 0; m_pfl = 0;
    end else begin
      exp_g(u0, u1);
      if (m_run() && req_0 && !u0) begin
        if (m_cnt == NROB) m_prob++;
        if (rs_free_cnt == 0) m_prs++;
        if (fl_free_cnt == 0) m_pfl++;
      end
      if (recovery_br) begin
        m_cnt = int'(recovery_cnt);
        m_block = RST;
        m_halted = 0;
      end else begin
        tot = m_cnt + int'(u0) + int'(u1)
              - int'(rt_valid_0) - int'(rt_valid_1);
        m_cnt = (tot < 0) ? 0 : tot;
        if (m_block > 0) m_block--;
        if ((u0 && halt_0) || (u1 && halt_1)) m_halted = 1;
      end
    end
  end

  bit c0, c1;
  always @(negedge clock) begin
    exp_g(c0, c1);
    chk("grant_0", grant_0, c0);
    chk("grant_1", grant_1, c1);
    chk("rob_count", rob_count, m_cnt);
    chk("rob_full", rob_full, m_cnt == NROB);
    chk("state", state,
        m_halted != 0 ? 2 : (m_block > 0 ? 1 : 0));
    chk("stall", stall, req_0 && !c0 && !reset);
`ifdef DISPATCH_PERF_CNT_EN
    chk("perf_rob", perf_stall_rob, m_prob);
    chk("perf_rs", perf_stall_rs, m_prs);
    chk("perf_fl", perf_stall_fl, m_pfl);
`endif
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_0 = 0; req_1 = 0; halt_0 = 0; halt_1 = 0;
    rt_valid_0 = 0; rt_valid_1 = 0; recovery_br = 0;
  endtask

  task automatic preload(input int n);
    idle();
    recovery_br = 1;
    recovery_cnt = 6'(n);
    cyc();
    recovery_br = 0;
    repeat (RST) cyc();
  endtask

  initial begin
    reset = 1;
    idle();
    rs_free_cnt = 5'd16;
    fl_free_cnt = 7'd64;
    recovery_cnt = '0;
    #2;
    chk("L_rst_cnt", rob_count, 0);
    chk("L_rst_state", state, 0);
    chk("L_rst_g0", grant_0, 0);
    cyc(); cyc();
    reset = 0;

    req_0 = 1; req_1 = 1;
    repeat (16) cyc();
    #1;
    chk("L_fill_cnt", rob_count, 32);
    chk("L_fill_full", rob_full, 1);
    chk("L_fill_g0", grant_0, 0);
    chk("L_fill_stall", stall, 1);

    preload(31);
    req_0 = 1; req_1 = 1;
    rs_free_cnt = 5'd5; fl_free_cnt = 7'd5;
    #1;
    chk("L_31_g0", grant_0, 1);
    chk("L_31_g1", grant_1, 0);
    cyc();
    chk("L_31_cnt", rob_count, 32);

    preload(20);
    req_0 = 1; req_1 = 1;
    rs_free_cnt = 5'd1; fl_free_cnt = 7'd64;
    #1;
    chk("L_rs1_g0", grant_0, 1);
    chk("L_rs1_g1", grant_1, 0);
    cyc();
    chk("L_rs1_cnt", rob_count, 21);
    rs_free_cnt = 5'd16;

    preload(10);
    req_0 = 1; req_1 = 1;
    rt_valid_0 = 1; rt_valid_1 = 1;
    cyc();
    chk("L_gr2_rt2", rob_count, 10);
    rt_valid_1 = 0;
    cyc();
    chk("L_gr2_rt1", rob_count, 11);
    idle();
    rt_valid_1 = 1;
    cyc();
    chk("L_rt1_only", rob_count, 10);

    preload(12);
    req_0 = 1; req_1 = 1;
    recovery_br = 1; recovery_cnt = 6'd4;
    #1;
    chk("L_rec_g0a", grant_0, 0);
    cyc();
    recovery_br = 0;
    #1;
    chk("L_rec_cnt", rob_count, 4);
    chk("L_rec_st1", state, 1);
    chk("L_rec_g0b", grant_0, 0);
    cyc();
    chk("L_rec_st2", state, 1);
    chk("L_rec_g0c", grant_0, 0);
    cyc();
    chk("L_rec_run", state, 0);
    chk("L_rec_g0d", grant_0, 1);
    chk("L_rec_g1d", grant_1, 1);
    cyc();
    chk("L_rec_cnt6", rob_count, 6);

    halt_0 = 1;
    #1;
    chk("L_h0_g0", grant_0, 1);
    chk("L_h0_g1", grant_1, 0);
    cyc();
    halt_0 = 0;
    #1;
    chk("L_h0_state", state, 2);
    chk("L_h0_nog", grant_0, 0);
    rt_valid_0 = 1;
    cyc();
    chk("L_hlt_rt", rob_count, 6);
    idle();
    cyc();
    recovery_br = 1; recovery_cnt = 6'd3;
    cyc();
    recovery_br = 0;
    chk("L_hrec_st", state, 1);
    cyc(); cyc();
    chk("L_hrec_run", state, 0);
    chk("L_hrec_cnt", rob_count, 3);

    req_0 = 1; req_1 = 1; halt_1 = 1;
    #1;
    chk("L_h1_g0", grant_0, 1);
    chk("L_h1_g1", grant_1, 1);
    cyc();
    chk("L_h1_state", state, 2);
    chk("L_h1_cnt", rob_count, 5);

    idle();
    recovery_br = 1; recovery_cnt = 6'd7;
    cyc();
    recovery_br = 0;
    cyc();
    req_0 = 1; req_1 = 1;
    #1;
    reset = 1;
    #1;
    chk("L_arst_cnt", rob_count, 0);
    chk("L_arst_state", state, 0);
    chk("L_arst_g0", grant_0, 0);
    chk("L_arst_stall", stall, 0);
`ifdef DISPATCH_PERF_CNT_EN
    chk("L_arst_prob", perf_stall_rob, 0);
`endif
    cyc();
    reset = 0;

    fl_free_cnt = 7'd0;
    #1;
    chk("L_fl0_g0", grant_0, 0);
    chk("L_fl0_stall", stall, 1);
    cyc();
    fl_free_cnt = 7'd64; rs_free_cnt = 5'd0;
    #1;
    chk("L_rs0_g0", grant_0, 0);
    cyc();
    rs_free_cnt = 5'd16; fl_free_cnt = 7'd1;
    #1;
    chk("L_fl1_g1", grant_1, 0);
    cyc();
    fl_free_cnt = 7'd2;
    cyc();
    chk("L_fl2_cnt", rob_count, 3);
    idle();
    rt_valid_0 = 1; rt_valid_1 = 1;
    cyc();
    chk("L_end_cnt", rob_count, 1);
    idle();
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
Dispatch-width controller in front of the ROB, RS and freelist. Each cycle it grants 0, 1 or 2 decoded instructions for in-order dispatch, based on the free space in all three structures. It tracks ROB occupancy with a counter and sequences the pipeline through branch recovery and halt. The grants drive the ROB fetch_PR_0/fetch_PR_1 dispatch-enable inputs and the matching RS and freelist allocate strobes.

Parameters:
N_ENTRY_ROB, 32, ROB depth; power of two, >= 4
N_ENTRY_RS, 16, RS depth
N_FREE_PR, 64, physical registers available to the freelist
RECOVER_STALL, 2, dispatch-blocked cycles after a recovery pulse; legal range 1..7

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-high
req_0  in  1  decoded instruction 0 valid (older)
req_1  in  1  decoded instruction 1 valid (younger)
halt_0  in  1  instruction 0 is a halt
halt_1  in  1  instruction 1 is a halt
rs_free_cnt  in  $clog2(N_ENTRY_RS+1)  free RS entries this cycle
fl_free_cnt  in  $clog2(N_FREE_PR+1)  free physical registers this cycle
rt_valid_0  in  1  ROB retiring its head entry this cycle
rt_valid_1  in  1  ROB retiring its second entry this cycle
recovery_br  in  1  mispredict recovery pulse (same signal the ROB receives)
recovery_cnt  in  $clog2(N_ENTRY_ROB+1)  ROB occupancy that remains after the squash
grant_0  out  1  dispatch instruction 0
grant_1  out  1  dispatch instruction 1
rob_count  out  $clog2(N_ENTRY_ROB+1)  registered ROB occupancy
rob_full  out  1  rob_count == N_ENTRY_ROB
state  out  2  00 RUN, 01 RECOVER, 10 HALTED
stall  out  1  req_0 asserted and grant_0 not asserted

Behaviour:
- Reset (asynchronous, immediate): rob_count=0, state=RUN, recovery counter=0, grant_0=grant_1=0 while reset is high, stall=0.
- Available space:
  - rob_space = N_ENTRY_ROB - rob_count.
  - space = min(rob_space, rs_free_cnt, fl_free_cnt), evaluated at full width with no truncation.
  - Retirements in the current cycle do not add to space. This is conservative: freed entries become usable next cycle.
- Grants (combinational from registered state and current inputs; no-glitch requirement only at the clock edge):
  - Grants are 0 unless state==RUN and recovery_br==0.
  - grant_0 = req_0 && space>=1.
  - grant_1 = grant_0 && req_1 && space>=2 && !halt_0.
  - Strictly in order: grant_1 never asserts without grant_0, even if req_0==0.
- Occupancy update:
  - Normal cycle: rob_count <= rob_count + grant_0 + grant_1 - rt_valid_0 - rt_valid_1.
  - rt_valid_1 without rt_valid_0 counts as one retire.
  - Retiring more than rob_count plus grants is illegal. Flag it with a simulation assertion; in RTL, saturate at 0.
- Recovery:
  - When recovery_br==1: rob_count <= recovery_cnt. Same-cycle grants are 0 and same-cycle retirements are ignored, because the ROB blocks retirement during recovery.
  - State goes to RECOVER and the recovery counter loads RECOVER_STALL-1.
  - RECOVER: counter decrements each cycle; at 0 with no new recovery_br, state goes to RUN.
  - A recovery_br arriving during RECOVER reloads rob_count and the counter.
- Halt:
  - When a granted instruction has halt set (grant_0&&halt_0, or grant_1&&halt_1), state goes to HALTED on the next edge.
  - HALTED: no grants; retirements still decrement rob_count.
  - recovery_br in HALTED goes to RECOVER, because the halt was speculative and has been squashed.
  - Only reset leaves HALTED otherwise.
- Simultaneous events:
  - recovery_br has priority over a halt grant in the same cycle (the grant is 0 anyway).
  - Grant and retire in the same cycle apply together, e.g. count 32, 2 retires, 0 grants gives 30.
- Boundaries:
  - rob_count==N_ENTRY_ROB gives rob_full=1, space=0, no grants.
  - rob_count==N_ENTRY_ROB-1 allows grant_0 only.
  - rob_count never exceeds N_ENTRY_ROB (assertion).

Optional Feature:
DISPATCH_PERF_CNT_EN:
- When defined, adds three outputs: perf_stall_rob, perf_stall_rs, perf_stall_fl (32 bits each, saturating).
  - Each increments in a cycle where state==RUN, req_0==1, grant_0==0, and its own structure is the limiting one (rob_space==0, rs_free_cnt==0, fl_free_cnt==0 respectively).
  - More than one may increment in the same cycle.
  - All reset to 0.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then req_0=req_1=1 and ample space for 16 cycles with no retire: grants 2/cycle, rob_count=32, rob_full=1 after cycle 16, then grants 0 and stall=1.
- rob_count=31, rs_free_cnt=5, fl_free_cnt=5, req_0=req_1=1: grant_0=1, grant_1=0; next rob_count=32. Repeat at count=20 with rs_free_cnt=1: grant_0 only.
- rob_count=10, grants 2, rt_valid_0=rt_valid_1=1: rob_count stays 10. Same with rt_valid_0 only: 11.
- RUN with rob_count=12, recovery_br=1 with recovery_cnt=4 and req high: grants 0 for RECOVER_STALL+1 cycles total, rob_count=4, then state=RUN and grants resume.
- req_0=req_1=1, halt_0=1: grant_0=1, grant_1=0, state=HALTED next cycle, no further grants. Then recovery_br with recovery_cnt=3 gives RECOVER, then RUN.
- Assert reset mid-RECOVER at rob_count=7: immediately rob_count=0, state=RUN, grants 0. With DISPATCH_PERF_CNT_EN, the perf counters also read 0.
